// File: rtl/gate_input_conditioner.sv
// Two-channel switch front end: each raw input is double-flop synchronised and
// debounced by a four-state FSM, producing clean levels, edge pulses and a change strobe.
module gate_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_a_raw,
    input  logic sw_b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic changed
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0] raw_vec;
    logic [1:0] level_vec;
    logic [1:0] rise_vec;
    logic [1:0] fall_vec;
    logic [1:0] rise_evt;
    logic [1:0] fall_evt;
    logic       changed_reg;

    assign raw_vec = {sw_b_raw, sw_a_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic             s1_reg;
            logic             s2_reg;
            state_t           state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             level_reg;
            logic             rise_reg;
            logic             fall_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= raw_vec[gi];
                    s2_reg <= s1_reg;
                end
            end

            // Qualifying edge of this cycle; shared by the pulse flops and the change strobe.
            assign rise_evt[gi] = (state_reg == WAIT_HI) && s2_reg && (cnt_reg == CNT_LAST);
            assign fall_evt[gi] = (state_reg == WAIT_LO) && !s2_reg && (cnt_reg == CNT_LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= STABLE_LO;
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    rise_reg <= rise_evt[gi];
                    fall_reg <= fall_evt[gi];
                    case (state_reg)
                        STABLE_LO: begin
                            if (s2_reg) begin
                                state_reg <= WAIT_HI;
                                cnt_reg   <= CNT_ONE;
                            end else begin
                                cnt_reg <= '0;
                            end
                        end
                        WAIT_HI: begin
                            if (!s2_reg) begin
                                state_reg <= STABLE_LO;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == CNT_LAST) begin
                                state_reg <= STABLE_HI;
                                cnt_reg   <= '0;
                                level_reg <= 1'b1;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_ONE;
                            end
                        end
                        STABLE_HI: begin
                            if (!s2_reg) begin
                                state_reg <= WAIT_LO;
                                cnt_reg   <= CNT_ONE;
                            end else begin
                                cnt_reg <= '0;
                            end
                        end
                        WAIT_LO: begin
                            if (s2_reg) begin
                                state_reg <= STABLE_HI;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == CNT_LAST) begin
                                state_reg <= STABLE_LO;
                                cnt_reg   <= '0;
                                level_reg <= 1'b0;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_ONE;
                            end
                        end
                        default: begin
                            state_reg <= STABLE_LO;
                            cnt_reg   <= '0;
                            level_reg <= 1'b0;
                        end
                    endcase
                end
            end

            assign level_vec[gi] = level_reg;
            assign rise_vec[gi]  = rise_reg;
            assign fall_vec[gi]  = fall_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= |{rise_evt, fall_evt};
        end
    end

    assign a       = level_vec[0];
    assign b       = level_vec[1];
    assign a_rise  = rise_vec[0];
    assign a_fall  = fall_vec[0];
    assign b_rise  = rise_vec[1];
    assign b_fall  = fall_vec[1];
    assign changed = changed_reg;

endmodule

// File: tb/tb_gate_input_conditioner.sv
// Directed bench for gate_input_conditioner with DEBOUNCE_CYCLES=4; outputs are
// checked as the vector {a, b, a_rise, a_fall, b_rise, b_fall, changed}.
module tb_gate_input_conditioner;

    logic clk;
    logic rst;
    logic sw_a_raw;
    logic sw_b_raw;
    logic a, b, a_rise, a_fall, b_rise, b_fall, changed;

    int pass_cnt  = 0;
    int total_cnt = 0;

    gate_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_a_raw (sw_a_raw),
        .sw_b_raw (sw_b_raw),
        .a        (a),
        .b        (b),
        .a_rise   (a_rise),
        .a_fall   (a_fall),
        .b_rise   (b_rise),
        .b_fall   (b_fall),
        .changed  (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] outs;
    assign outs = {a, b, a_rise, a_fall, b_rise, b_fall, changed};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw_a_raw = 1'b1;
        sw_b_raw = 1'b1;
        #1;
        total_cnt++;
        if (outs !== 7'b0) $display("FAIL reset_pre_clock: outs=%b required=%b", outs, 7'b0);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            tick();
            total_cnt++;
            if (outs !== 7'b0) $display("FAIL reset_hold[%0d]: outs=%b required=%b", i, outs, 7'b0);
            else pass_cnt++;
        end
        sw_a_raw = 1'b0;
        sw_b_raw = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total_cnt++;
        if (outs !== 7'b0) $display("FAIL reset_release: outs=%b required=%b", outs, 7'b0);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_clean_press();
        logic [6:0] exp;
        sw_a_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = (e < 6) ? 7'b0000000 : (e == 6) ? 7'b1010001 : 7'b1000000;
            total_cnt++;
            if (outs !== exp) $display("FAIL clean_press_edge%0d: outs=%b required=%b", e, outs, exp);
            else pass_cnt++;
        end
        $display("test_clean_press done");
    endtask

    task automatic test_b_press();
        logic [6:0] exp;
        sw_b_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = (e < 6) ? 7'b1000000 : (e == 6) ? 7'b1100101 : 7'b1100000;
            total_cnt++;
            if (outs !== exp) $display("FAIL b_press_edge%0d: outs=%b required=%b", e, outs, exp);
            else pass_cnt++;
        end
        $display("test_b_press done");
    endtask

    task automatic test_release_simultaneous();
        logic [6:0] exp;
        sw_a_raw = 1'b0;
        sw_b_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = (e < 6) ? 7'b1100000 : (e == 6) ? 7'b0001011 : 7'b0000000;
            total_cnt++;
            if (outs !== exp) $display("FAIL release_edge%0d: outs=%b required=%b", e, outs, exp);
            else pass_cnt++;
        end
        $display("test_release_simultaneous done");
    endtask

    task automatic test_bounce();
        logic [6:0] exp;
        sw_a_raw = 1'b1;
        for (int e = 1; e <= 3; e++) tick();
        sw_a_raw = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            total_cnt++;
            if (outs !== 7'b0) $display("FAIL bounce_short%0d: outs=%b required=%b", e, outs, 7'b0);
            else pass_cnt++;
        end
        sw_a_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = (e < 6) ? 7'b0000000 : (e == 6) ? 7'b1010001 : 7'b1000000;
            total_cnt++;
            if (outs !== exp) $display("FAIL bounce_long_edge%0d: outs=%b required=%b", e, outs, exp);
            else pass_cnt++;
        end
        $display("test_bounce done");
    endtask

    task automatic test_reset_mid_wait();
        logic [6:0] exp;
        // a is 1 here; reset must clear it without waiting for a clock edge
        rst = 1'b1;
        #1;
        total_cnt++;
        if (outs !== 7'b0) $display("FAIL async_reset: outs=%b required=%b", outs, 7'b0);
        else pass_cnt++;
        sw_a_raw = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        sw_a_raw = 1'b1;
        for (int e = 1; e <= 3; e++) tick();
        rst = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            tick();
            total_cnt++;
            if (outs !== 7'b0) $display("FAIL mid_wait_reset%0d: outs=%b required=%b", e, outs, 7'b0);
            else pass_cnt++;
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = (e < 6) ? 7'b0000000 : (e == 6) ? 7'b1010001 : 7'b1000000;
            total_cnt++;
            if (outs !== exp) $display("FAIL post_reset_edge%0d: outs=%b required=%b", e, outs, exp);
            else pass_cnt++;
        end
        $display("test_reset_mid_wait done");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_b_press();
        test_release_simultaneous();
        test_bounce();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
